// File: rtl/crc_word_framer_if.sv
// Handshake bundle between the word framer, its upstream producer, the serial
// CRC engine and the downstream frame consumer.
interface crc_word_framer_if #(
  parameter int WORD_W = 32,
  parameter int CRC_W  = 16
);
  logic [WORD_W-1:0]       word_in;
  logic                    word_valid_in;
  logic                    word_ready_out;
  logic                    crc_start_out;
  logic                    crc_data_out;
  logic                    crc_done_in;
  logic [CRC_W-1:0]        crc_r_in;
  logic [WORD_W+CRC_W-1:0] frame_out;
  logic                    frame_valid_out;
  logic                    frame_ready_in;
  logic                    err_out;

  modport slave (
    input  word_in, word_valid_in, crc_done_in, crc_r_in, frame_ready_in,
    output word_ready_out, crc_start_out, crc_data_out, frame_out,
           frame_valid_out, err_out
  );

  modport master (
    output word_in, word_valid_in, crc_done_in, crc_r_in, frame_ready_in,
    input  word_ready_out, crc_start_out, crc_data_out, frame_out,
           frame_valid_out, err_out
  );
endinterface

// File: rtl/crc_word_framer.sv
// Feeds one word MSB-first into the serial CRC engine, captures the remainder
// and presents {word, crc} downstream; aborts with err_out if done never comes.
//
// state     | meaning
// IDLE      | ready for a new word
// START     | one-cycle start pulse to the engine
// SHIFT     | WORD_W serial bits, MSB first
// WAIT_DONE | waiting for engine done, bounded by TIMEOUT_CYC
// OUTPUT    | frame valid until the consumer accepts it
module crc_word_framer #(
  parameter int WORD_W      = 32,
  parameter int CRC_W       = 16,
  parameter int TIMEOUT_CYC = 8
) (
  input logic              clk_in,
  input logic              rst_in,
  crc_word_framer_if.slave bus
);
  localparam int BIT_CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int TO_CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WORD_W - 1);
  localparam logic [TO_CNT_W-1:0]  LAST_TO  = TO_CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SHIFT,
    S_WAIT_DONE,
    S_OUTPUT
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [WORD_W-1:0]     r_shift, w_shift_nxt;
  logic [WORD_W-1:0]     r_word_hold, w_word_hold_nxt;
  logic [CRC_W-1:0]      r_crc_hold, w_crc_hold_nxt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [TO_CNT_W-1:0]   r_to_cnt, w_to_cnt_nxt;
  logic                  r_word_ready, w_word_ready_nxt;
  logic                  r_crc_start, w_crc_start_nxt;
  logic                  r_crc_data, w_crc_data_nxt;
  logic                  r_frame_valid, w_frame_valid_nxt;
  logic                  r_err, w_err_nxt;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state       <= S_IDLE;
      r_shift       <= '0;
      r_word_hold   <= '0;
      r_crc_hold    <= '0;
      r_bit_cnt     <= '0;
      r_to_cnt      <= '0;
      r_word_ready  <= 1'b1;
      r_crc_start   <= 1'b0;
      r_crc_data    <= 1'b0;
      r_frame_valid <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_shift       <= w_shift_nxt;
      r_word_hold   <= w_word_hold_nxt;
      r_crc_hold    <= w_crc_hold_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_to_cnt      <= w_to_cnt_nxt;
      r_word_ready  <= w_word_ready_nxt;
      r_crc_start   <= w_crc_start_nxt;
      r_crc_data    <= w_crc_data_nxt;
      r_frame_valid <= w_frame_valid_nxt;
      r_err         <= w_err_nxt;
    end
  end

  // Outputs are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    w_state_nxt       = r_state;
    w_shift_nxt       = r_shift;
    w_word_hold_nxt   = r_word_hold;
    w_crc_hold_nxt    = r_crc_hold;
    w_bit_cnt_nxt     = r_bit_cnt;
    w_to_cnt_nxt      = r_to_cnt;
    w_word_ready_nxt  = r_word_ready;
    w_frame_valid_nxt = r_frame_valid;
    w_crc_start_nxt   = 1'b0;
    w_crc_data_nxt    = 1'b0;
    w_err_nxt         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.word_valid_in && r_word_ready) begin
          w_shift_nxt      = bus.word_in;
          w_word_hold_nxt  = bus.word_in;
          w_word_ready_nxt = 1'b0;
          w_crc_start_nxt  = 1'b1;
          w_state_nxt      = S_START;
        end
      end
      S_START: begin
        w_bit_cnt_nxt  = '0;
        w_crc_data_nxt = r_shift[WORD_W-1];
        w_shift_nxt    = {r_shift[WORD_W-2:0], 1'b0};
        w_state_nxt    = S_SHIFT;
      end
      S_SHIFT: begin
        if (r_bit_cnt == LAST_BIT) begin
          w_to_cnt_nxt = '0;
          w_state_nxt  = S_WAIT_DONE;
        end else begin
          w_crc_data_nxt = r_shift[WORD_W-1];
          w_shift_nxt    = {r_shift[WORD_W-2:0], 1'b0};
          w_bit_cnt_nxt  = r_bit_cnt + BIT_CNT_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (bus.crc_done_in) begin
          w_crc_hold_nxt    = bus.crc_r_in;
          w_frame_valid_nxt = 1'b1;
          w_state_nxt       = S_OUTPUT;
        end else if (r_to_cnt == LAST_TO) begin
          w_to_cnt_nxt     = '0;
          w_err_nxt        = 1'b1;
          w_word_ready_nxt = 1'b1;
          w_state_nxt      = S_IDLE;
        end else begin
          w_to_cnt_nxt = r_to_cnt + TO_CNT_W'(1);
        end
      end
      S_OUTPUT: begin
        if (bus.frame_ready_in) begin
          w_frame_valid_nxt = 1'b0;
          w_word_ready_nxt  = 1'b1;
          w_state_nxt       = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.word_ready_out  = r_word_ready;
  assign bus.crc_start_out   = r_crc_start;
  assign bus.crc_data_out    = r_crc_data;
  assign bus.frame_valid_out = r_frame_valid;
  assign bus.frame_out       = {r_word_hold, r_crc_hold};
  assign bus.err_out         = r_err;
endmodule

// File: tb/tb_crc_word_framer.sv
// Bench for crc_word_framer: behavioural serial-CRC engine stub plus a
// frame/latency reference model derived from the engine contract.
module tb_crc_word_framer;
  localparam int WORD_W = 32;
  localparam int CRC_W  = 16;
  localparam int TO_CYC = 8;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  crc_word_framer_if #(.WORD_W(WORD_W), .CRC_W(CRC_W)) bus ();

  crc_word_framer #(.WORD_W(WORD_W), .CRC_W(CRC_W), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // engine stub: mode 0 = compliant, 1 = never done, 2 = done stuck high
  int          stub_mode = 0;
  logic [15:0] stub_crc  = 16'hBEEF;
  logic [31:0] stub_bits = '0;
  int          stub_cnt  = 0;
  int          start_cnt = 0;
  int          start_cyc[$];

  assign bus.crc_r_in = stub_crc;

  always @(posedge clk_in) begin
    if (rst_in) begin
      stub_cnt        <= 0;
      bus.crc_done_in <= (stub_mode == 2);
    end else if (bus.crc_start_out) begin
      stub_cnt        <= 1;
      stub_bits       <= '0;
      start_cnt       <= start_cnt + 1;
      start_cyc.push_back(cyc);
      bus.crc_done_in <= (stub_mode == 2);
    end else if (stub_cnt >= 1 && stub_cnt <= 32) begin
      stub_bits <= {stub_bits[30:0], bus.crc_data_out};
      stub_cnt  <= stub_cnt + 1;
      if (stub_cnt == 32) bus.crc_done_in <= (stub_mode != 1);
    end else begin
      if (stub_mode == 2) bus.crc_done_in <= 1'b1;
      else if (stub_mode == 1) bus.crc_done_in <= 1'b0;
    end
  end

  typedef struct {
    int          n_start;
    int          start_c;
    int          valid_c;
    logic [47:0] frame;
    int          n_err;
    int          err_c;
    logic [31:0] bits_seen;
    int          data_bad;
    int          ready_c;
    bit          ready_after_err;
  } obs_t;

  // Watches n cycles starting at the current negedge; cycle offsets are relative to t0.
  task automatic observe(input int t0, input int n, output obs_t o);
    o.n_start = 0; o.start_c = -1; o.valid_c = -1; o.frame = '0;
    o.n_err = 0; o.err_c = -1; o.bits_seen = '0; o.data_bad = 0;
    o.ready_c = -1; o.ready_after_err = 1'b0;
    for (int k = 0; k < n; k++) begin
      int c;
      c = cyc - t0;
      if (bus.crc_start_out === 1'b1) begin o.n_start++; o.start_c = c; end
      if (bus.frame_valid_out === 1'b1 && o.valid_c < 0) begin
        o.valid_c = c; o.frame = bus.frame_out;
      end
      if (o.n_err > 0 && c == o.err_c + 1) o.ready_after_err = bus.word_ready_out;
      if (bus.err_out === 1'b1) begin o.n_err++; o.err_c = c; end
      if (c >= 2 && c <= 33) o.bits_seen[33-c] = bus.crc_data_out;
      else if (bus.crc_data_out !== 1'b0) o.data_bad++;
      if (c >= 2 && o.ready_c < 0 && bus.word_ready_out === 1'b1) o.ready_c = c;
      @(negedge clk_in);
    end
  endtask

  // Offers a word; returns at the negedge of cycle T+1 with t_acc = T.
  task automatic accept_word(input logic [31:0] w, input bit keep_valid, output int t_acc);
    bit ok;
    ok = 1'b0;
    t_acc = -1;
    @(negedge clk_in);
    bus.word_in = w;
    bus.word_valid_in = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (bus.word_ready_out === 1'b1) begin ok = 1'b1; t_acc = cyc; break; end
      @(negedge clk_in);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: word %08h never accepted, ready=%b", w, bus.word_ready_out);
    end
    @(negedge clk_in);
    if (!keep_valid) bus.word_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    checks++;
    if ({bus.crc_start_out, bus.crc_data_out, bus.frame_valid_out, bus.err_out} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: start/data/valid/err=%b want 0000",
               {bus.crc_start_out, bus.crc_data_out, bus.frame_valid_out, bus.err_out});
    end
    checks++;
    if (bus.frame_out !== 48'h0) begin
      errors++; $display("FAIL reset_frame: got %012h want 0", bus.frame_out);
    end
    rst_in = 1'b0;
    @(negedge clk_in);
    checks++;
    if (bus.word_ready_out !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", bus.word_ready_out);
    end
  endtask

  task automatic test_nominal();
    int t; obs_t o;
    logic [31:0] w;
    w = 32'hA5C3_0F01;
    stub_mode = 0; stub_crc = 16'hBEEF; bus.frame_ready_in = 1'b1;
    accept_word(w, 1'b0, t);
    observe(t, 40, o);
    checks++;
    if (o.n_start != 1 || o.start_c != 1) begin
      errors++; $display("FAIL nom_start: pulses=%0d at +%0d want 1 at +1", o.n_start, o.start_c);
    end
    checks++;
    if (stub_bits !== w || o.bits_seen !== w) begin
      errors++; $display("FAIL nom_bits: stub=%08h seen=%08h want %08h", stub_bits, o.bits_seen, w);
    end
    checks++;
    if (o.valid_c != 35 || o.frame !== {w, 16'hBEEF}) begin
      errors++; $display("FAIL nom_frame: %012h at +%0d want %012h at +35", o.frame, o.valid_c, {w, 16'hBEEF});
    end
    checks++;
    if (o.ready_c != 36 || o.data_bad != 0 || o.n_err != 0) begin
      errors++; $display("FAIL nom_misc: ready at +%0d want +36, stray data=%0d, err=%0d",
                         o.ready_c, o.data_bad, o.n_err);
    end
  endtask

  task automatic test_backpressure();
    int t, f, s0, bad_hold, bad_ready; obs_t o;
    logic [47:0] exp1;
    exp1 = {32'hA5C3_0F01, 16'hBEEF};
    stub_mode = 0; stub_crc = 16'hBEEF; bus.frame_ready_in = 1'b0;
    accept_word(32'hA5C3_0F01, 1'b0, t);
    f = -1;
    for (int k = 0; k < 60; k++) begin
      if (bus.frame_valid_out === 1'b1) begin f = cyc; break; end
      @(negedge clk_in);
    end
    checks++;
    if (f - t != 35) begin
      errors++; $display("FAIL bp_latency: valid at +%0d want +35", f - t);
    end
    s0 = start_cnt;
    bus.word_in = 32'h1234_5678; bus.word_valid_in = 1'b1;
    bad_hold = 0; bad_ready = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.frame_out !== exp1 || bus.frame_valid_out !== 1'b1) bad_hold++;
      if (bus.word_ready_out !== 1'b0) bad_ready++;
      @(negedge clk_in);
    end
    checks++;
    if (bad_hold != 0) begin
      errors++; $display("FAIL bp_hold: %0d cycles frame %012h want %012h", bad_hold, bus.frame_out, exp1);
    end
    checks++;
    if (bad_ready != 0 || start_cnt != s0) begin
      errors++; $display("FAIL bp_stall: ready high %0d cycles, starts %0d want %0d", bad_ready, start_cnt, s0);
    end
    bus.frame_ready_in = 1'b1;
    @(negedge clk_in);
    checks++;
    if (bus.word_ready_out !== 1'b1 || bus.frame_valid_out !== 1'b0 || bus.crc_start_out !== 1'b0) begin
      errors++; $display("FAIL bp_release: ready=%b valid=%b start=%b want 1 0 0",
                         bus.word_ready_out, bus.frame_valid_out, bus.crc_start_out);
    end
    t = cyc;
    @(negedge clk_in);
    bus.word_valid_in = 1'b0;
    observe(t, 40, o);
    checks++;
    if (o.n_start != 1 || o.start_c != 1 || o.valid_c != 35 || o.frame !== {32'h1234_5678, 16'hBEEF}) begin
      errors++; $display("FAIL bp_second: start=%0d@+%0d frame=%012h@+%0d want 1@+1 %012h@+35",
                         o.n_start, o.start_c, o.frame, o.valid_c, {32'h1234_5678, 16'hBEEF});
    end
  endtask

  task automatic test_timeout();
    int t; obs_t o;
    stub_mode = 1; bus.frame_ready_in = 1'b1;
    accept_word(32'h0F0F_3C3C, 1'b0, t);
    observe(t, 50, o);
    checks++;
    if (o.n_err != 1 || o.err_c != 34 + TO_CYC) begin
      errors++; $display("FAIL to_err: pulses=%0d at +%0d want 1 at +%0d", o.n_err, o.err_c, 34 + TO_CYC);
    end
    checks++;
    if (o.valid_c != -1 || o.ready_after_err !== 1'b1) begin
      errors++; $display("FAIL to_after: valid at +%0d want none, ready after err=%b want 1",
                         o.valid_c, o.ready_after_err);
    end
    stub_mode = 0;
  endtask

  task automatic test_stale_done();
    int t; obs_t o;
    stub_mode = 2; stub_crc = 16'h5A17; bus.frame_ready_in = 1'b1;
    accept_word(32'hC001_D00D, 1'b0, t);
    observe(t, 40, o);
    checks++;
    if (o.valid_c != 35 || o.frame !== {32'hC001_D00D, 16'h5A17}) begin
      errors++; $display("FAIL stale: frame %012h at +%0d want %012h at +35",
                         o.frame, o.valid_c, {32'hC001_D00D, 16'h5A17});
    end
    checks++;
    if (o.bits_seen !== 32'hC001_D00D || o.n_start != 1) begin
      errors++; $display("FAIL stale_bits: %08h starts=%0d want C001D00D 1", o.bits_seen, o.n_start);
    end
    stub_mode = 0; stub_crc = 16'hBEEF;
  endtask

  task automatic test_mid_reset();
    int t; obs_t o;
    stub_mode = 0; stub_crc = 16'hBEEF; bus.frame_ready_in = 1'b1;
    accept_word(32'hDEAD_BEEF, 1'b0, t);
    repeat (19) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    checks++;
    if ({bus.word_ready_out, bus.crc_start_out, bus.crc_data_out, bus.frame_valid_out, bus.err_out} !== 5'b10000
        || bus.frame_out !== 48'h0) begin
      errors++; $display("FAIL midrst_outs: rdy/st/dat/vld/err=%b frame=%012h want 10000 0",
                         {bus.word_ready_out, bus.crc_start_out, bus.crc_data_out, bus.frame_valid_out, bus.err_out},
                         bus.frame_out);
    end
    accept_word(32'h0000_0001, 1'b0, t);
    observe(t, 40, o);
    checks++;
    if (o.n_start != 1 || o.bits_seen !== 32'h1 || stub_bits !== 32'h1) begin
      errors++; $display("FAIL midrst_bits: starts=%0d seen=%08h stub=%08h want 1 00000001", o.n_start, o.bits_seen, stub_bits);
    end
    checks++;
    if (o.valid_c != 35 || o.frame !== {32'h1, 16'hBEEF}) begin
      errors++; $display("FAIL midrst_frame: %012h at +%0d want %012h at +35", o.frame, o.valid_c, {32'h1, 16'hBEEF});
    end
  endtask

  task automatic test_back_to_back();
    int t, n0; bit acc2;
    logic [47:0] fq[$];
    stub_mode = 0; stub_crc = 16'hBEEF; bus.frame_ready_in = 1'b1;
    n0 = start_cyc.size();
    accept_word(32'hFFFF_FFFF, 1'b1, t);
    bus.word_in = 32'h0;
    acc2 = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (bus.frame_valid_out === 1'b1) fq.push_back(bus.frame_out);
      if (acc2) bus.word_valid_in = 1'b0;
      else if (bus.word_ready_out === 1'b1) acc2 = 1'b1;
      @(negedge clk_in);
    end
    bus.word_valid_in = 1'b0;
    checks++;
    if (fq.size() != 2) begin
      errors++; $display("FAIL b2b_count: %0d frames want 2", fq.size());
    end else begin
      checks++;
      if (fq[0] !== {32'hFFFF_FFFF, 16'hBEEF} || fq[1] !== {32'h0, 16'hBEEF}) begin
        errors++; $display("FAIL b2b_order: %012h %012h want FFFFFFFFBEEF 00000000BEEF", fq[0], fq[1]);
      end
    end
    checks++;
    if (start_cyc.size() != n0 + 2) begin
      errors++; $display("FAIL b2b_starts: %0d starts want 2", start_cyc.size() - n0);
    end else begin
      checks++;
      if (start_cyc[n0+1] - start_cyc[n0] < 36) begin
        errors++; $display("FAIL b2b_gap: %0d cycles want >=36", start_cyc[n0+1] - start_cyc[n0]);
      end
    end
  endtask

  task automatic test_random();
    int t; obs_t o;
    logic [31:0] w;
    logic [15:0] c;
    stub_mode = 0; bus.frame_ready_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w = $urandom;
      c = 16'($urandom);
      stub_crc = c;
      repeat ($urandom_range(0, 3)) @(negedge clk_in);
      accept_word(w, 1'b0, t);
      observe(t, 40, o);
      checks++;
      if (o.valid_c != 35 || o.frame !== {w, c} || o.bits_seen !== w || o.n_start != 1 || o.data_bad != 0) begin
        errors++; $display("FAIL rand_%0d: frame %012h@+%0d bits %08h starts %0d stray %0d want %012h@+35 bits %08h",
                           i, o.frame, o.valid_c, o.bits_seen, o.n_start, o.data_bad, {w, c}, w);
      end
    end
  endtask

  initial begin
    bus.word_in = '0;
    bus.word_valid_in = 1'b0;
    bus.frame_ready_in = 1'b1;
    test_reset();
    test_nominal();
    test_backpressure();
    test_timeout();
    test_stale_done();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/crc_word_framer.md
Name: crc_word_framer

Overview:
- Upstream/downstream wrapper for the team's serial CRC-16 engine (`crc`).
- Accepts a 32-bit word over a valid/ready handshake and drives the engine's start pulse and serial data bit, MSB first.
- Waits for the engine's done flag, captures its 16-bit remainder, and presents a 48-bit frame {word, crc} on a valid/ready output handshake.
- Detects a missing done with a timeout.

Parameters:
- WORD_W, 32, word width and number of serial bits; must equal the engine's fixed 32-bit message length.
- CRC_W, 16, remainder width captured from the engine.
- TIMEOUT_CYC, 8, cycles to wait in WAIT_DONE for crc_done_in before aborting.

Ports:
- clk_in  input  1  system clock; all logic on posedge.
- rst_in  input  1  synchronous, active-high reset.
- word_in  input  WORD_W  message word.
- word_valid_in  input  1  word_in valid.
- word_ready_out  output  1  framer can accept a word (high only in IDLE).
- crc_start_out  output  1  one-cycle start pulse to the CRC engine.
- crc_data_out  output  1  serial message bit to the CRC engine.
- crc_done_in  input  1  engine done (level; stays high until next start).
- crc_r_in  input  CRC_W  engine remainder.
- frame_out  output  WORD_W+CRC_W  {word, crc}; word in MSBs.
- frame_valid_out  output  1  frame_out valid.
- frame_ready_in  input  1  consumer accepts frame.
- err_out  output  1  one-cycle pulse on timeout abort.

Behaviour:
- Engine contract (fixed):
  - Start cycle S resets the engine.
  - Engine samples crc_data_out on cycles S+1 .. S+32 (32 bits).
  - crc_done_in is high from cycle S+33 until the next start.
- All state and outputs are registered.
- States: IDLE, START, SHIFT, WAIT_DONE, OUTPUT.
- IDLE:
  - word_ready_out=1.
  - On word_valid_in & word_ready_out (cycle T): latch word_in into shift_reg and word_hold, then go to START.
- START (T+1):
  - crc_start_out=1, crc_data_out=0.
  - Clear bit counter; go to SHIFT.
- SHIFT (T+2 .. T+33):
  - crc_data_out = shift_reg[WORD_W-1].
  - Shift left by 1 each cycle; increment the bit counter.
  - After the 32nd bit cycle (counter = WORD_W-1), go to WAIT_DONE.
  - crc_done_in is ignored in SHIFT.
- WAIT_DONE (entered at T+34):
  - Clear timeout counter on entry.
  - If crc_done_in: capture crc_r_in into crc_hold, go to OUTPUT.
  - Else increment the counter; when it reaches TIMEOUT_CYC-1 without done: err_out=1 for one cycle, go to IDLE, no frame emitted.
- OUTPUT:
  - frame_valid_out=1, frame_out={word_hold, crc_hold}.
  - frame_out stays stable while frame_valid_out & ~frame_ready_in.
  - On frame_ready_in: drop valid next cycle, go to IDLE.
- Nominal latency with a compliant engine and frame_ready_in held high:
  - Accept at T.
  - crc_start_out at T+1.
  - Bits at T+2..T+33.
  - Capture at T+34.
  - frame_valid_out high at T+35.
  - word_ready_out high again at T+36.
- Throughput: one word per 36 cycles minimum; back-pressure on frame_ready_in stalls acceptance.
- crc_start_out is high for exactly one cycle per accepted word and never outside START.
- crc_data_out is 0 in every state except SHIFT.
- Stale high crc_done_in from a previous run is never sampled, because WAIT_DONE is entered only after a fresh start.
- Reset values (rst_in=1 at any time, including mid-SHIFT or mid-OUTPUT):
  - State=IDLE.
  - word_ready_out=1 after reset deasserts.
  - crc_start_out=0, crc_data_out=0.
  - frame_valid_out=0, frame_out=0, err_out=0.
  - All counters 0.
  - The in-progress word is discarded; the engine's partial state is irrelevant because the next word issues a new start.
- word_valid_in during non-IDLE states is ignored (word_ready_out=0); the upstream must hold it.

Test Plan:
1. Behavioural engine stub (records 32 sampled bits, asserts done at S+33, returns 16'hBEEF), word_in=32'hA5C3_0F01, frame_ready_in=1:
   - crc_start_out pulses once at T+1.
   - Stub records bits MSB first, equal to A5C30F01.
   - frame_out=48'hA5C3_0F01_BEEF, valid at T+35.
2. Same stub, frame_ready_in=0 for 10 cycles after valid:
   - frame_out holds 48'hA5C3_0F01_BEEF.
   - word_ready_out stays 0.
   - A new word offered during the stall is not accepted until the cycle after frame_ready_in=1.
3. Stub never asserts done, TIMEOUT_CYC=8:
   - err_out pulses exactly once, 8 cycles after WAIT_DONE entry.
   - No frame_valid_out.
   - word_ready_out=1 next cycle.
4. Stub holds crc_done_in=1 throughout (stale level):
   - No capture before T+34.
   - Frame still appears at T+35 with the stub's remainder.
5. rst_in asserted at T+20 (mid-SHIFT) for one cycle:
   - Next cycle all outputs are at reset values, word_ready_out=1.
   - A subsequent word 32'h0000_0001 produces a fresh start and a correct 32-bit serial pattern.
6. Back-to-back valid words 32'hFFFF_FFFF and 32'h0:
   - Two separate start pulses at least 36 cycles apart.
   - Frames emitted in order with the correct word fields.
